// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit: state codes, opcodes,
// ULA operation codes and instruction classes.
package controle_multiciclo_pkg;

    typedef enum logic [2:0] {
        BUSCA = 3'd0,
        DECOD = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        ESCR  = 3'd4,
        ERRO  = 3'd7
    } estado_t;

    typedef enum logic [2:0] {
        CL_NENHUMA = 3'd0,
        CL_R       = 3'd1,
        CL_I       = 3'd2,
        CL_LOAD    = 3'd3,
        CL_STORE   = 3'd4,
        CL_BRANCH  = 3'd5
    } classe_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    localparam int MEM_TIMEOUT_DEF = 15;
    localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/controle_multiciclo_decod.sv
// Combinational instruction decoder: opcode/f3/f7 to class, ULA operation,
// datapath selects and an illegal-instruction flag.
module decod_instr
    import controle_multiciclo_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    output classe_t    classe,
    output logic [3:0] alu_op,
    output logic       alu_src,
    output logic [2:0] tipo_branch,
    output logic       sel_slt,
    output logic       ilegal
);

    logic eh_r;
    logic f7_ok;

    assign eh_r  = (opcode == OP_R);
    // Immediate forms ignore f7 except where it selects the shift flavour.
    assign f7_ok = !eh_r || (f7 == F7_BASE);

    always_comb begin
        classe      = CL_NENHUMA;
        alu_op      = ALU_ADD;
        alu_src     = 1'b0;
        tipo_branch = '0;
        sel_slt     = 1'b0;
        ilegal      = 1'b0;

        case (opcode)
            OP_R, OP_I: begin
                classe  = eh_r ? CL_R : CL_I;
                alu_src = !eh_r;
                sel_slt = (f3 == 3'b010);
                case (f3)
                    3'b000: begin
                        if (f7_ok)              alu_op = ALU_ADD;
                        else if (f7 == F7_ALT)  alu_op = ALU_SUB;
                        else                    ilegal = 1'b1;
                    end
                    3'b001: begin
                        alu_op = ALU_SLL;
                        ilegal = (f7 != F7_BASE);
                    end
                    3'b010: begin
                        alu_op = ALU_SLT;
                        ilegal = !f7_ok;
                    end
                    3'b100: begin
                        alu_op = ALU_XOR;
                        ilegal = !f7_ok;
                    end
                    3'b101: begin
                        if (f7 == F7_BASE)      alu_op = ALU_SRL;
                        else if (f7 == F7_ALT)  alu_op = ALU_SRA;
                        else                    ilegal = 1'b1;
                    end
                    3'b110: begin
                        alu_op = ALU_OR;
                        ilegal = !f7_ok;
                    end
                    3'b111: begin
                        alu_op = ALU_AND;
                        ilegal = !f7_ok;
                    end
                    default: ilegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                classe  = CL_LOAD;
                alu_src = 1'b1;
            end
            OP_STORE: begin
                classe  = CL_STORE;
                alu_src = 1'b1;
            end
            OP_BRANCH: begin
                classe      = CL_BRANCH;
                alu_op      = ALU_SUB;
                tipo_branch = f3;
                ilegal      = (f3 == 3'b010) || (f3 == 3'b011);
            end
            default: ilegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle processor control unit: fetch/decode/execute/memory/writeback FSM
// with memory-wait timeout, sticky fault state and retired-instruction counter.
module controle_multiciclo
    import controle_multiciclo_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       f3,
    input  logic [6:0]       f7,
    input  logic             mem_pronto,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             regWrite,
    output logic             MemWrite,
    output logic             mem_req,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic             SeltipoSouB,
    output logic             selSLT,
    output logic             PCSrc,
    output logic [3:0]       ALUOp,
    output logic [2:0]       Tipo_Branch,
    output logic [2:0]       estado,
    output logic             erro,
    output logic [CNT_W-1:0] instr_ret
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

    estado_t          state_q, state_d;
    classe_t          classe_q;
    logic [3:0]       alu_op_q;
    logic             alu_src_q;
    logic [2:0]       tipo_q;
    logic             slt_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0] cnt_q;

    classe_t          dec_classe;
    logic [3:0]       dec_alu_op;
    logic             dec_alu_src;
    logic [2:0]       dec_tipo;
    logic             dec_slt;
    logic             dec_ilegal;

    logic ir_wr_c, pc_wr_c, reg_wr_c, mem_wr_c, mem_req_c;

    decod_instr u_decod (
        .opcode      (opcode),
        .f3          (f3),
        .f7          (f7),
        .classe      (dec_classe),
        .alu_op      (dec_alu_op),
        .alu_src     (dec_alu_src),
        .tipo_branch (dec_tipo),
        .sel_slt     (dec_slt),
        .ilegal      (dec_ilegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BUSCA;
            classe_q  <= CL_NENHUMA;
            alu_op_q  <= '0;
            alu_src_q <= 1'b0;
            tipo_q    <= '0;
            slt_q     <= 1'b0;
            wait_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECOD) begin
                classe_q  <= dec_classe;
                alu_op_q  <= dec_alu_op;
                alu_src_q <= dec_alu_src;
                tipo_q    <= dec_tipo;
                slt_q     <= dec_slt;
            end
            // Held at zero outside MEM, so every MEM visit starts counting afresh.
            if (state_q == MEM && !mem_pronto) wait_q <= wait_q + 1'b1;
            else                               wait_q <= '0;
            if (pc_wr) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_wr_c     = 1'b0;
        pc_wr_c     = 1'b0;
        reg_wr_c    = 1'b0;
        mem_wr_c    = 1'b0;
        mem_req_c   = 1'b0;
        MemToReg    = 1'b0;
        SeltipoSouB = 1'b0;
        selSLT      = 1'b0;
        PCSrc       = 1'b0;

        case (state_q)
            BUSCA: begin
                ir_wr_c = 1'b1;
                state_d = DECOD;
            end
            DECOD: state_d = dec_ilegal ? ERRO : EXEC;
            EXEC: begin
                case (classe_q)
                    CL_R, CL_I:        state_d = ESCR;
                    CL_LOAD, CL_STORE: state_d = MEM;
                    CL_BRANCH: begin
                        pc_wr_c = 1'b1;
                        PCSrc   = 1'b1;
                        state_d = BUSCA;
                    end
                    default:           state_d = ERRO;
                endcase
            end
            MEM: begin
                mem_req_c   = 1'b1;
                mem_wr_c    = (classe_q == CL_STORE);
                SeltipoSouB = (classe_q == CL_STORE);
                if (mem_pronto) begin
                    if (classe_q == CL_STORE) begin
                        pc_wr_c = 1'b1;
                        state_d = BUSCA;
                    end else begin
                        state_d = ESCR;
                    end
                end else if (wait_q == WAIT_MAX) begin
                    state_d = ERRO;
                end
            end
            ESCR: begin
                reg_wr_c = 1'b1;
                pc_wr_c  = 1'b1;
                MemToReg = (classe_q == CL_LOAD);
                selSLT   = slt_q;
                state_d  = BUSCA;
            end
            ERRO:    state_d = ERRO;
            default: state_d = ERRO;
        endcase
    end

    assign ir_wr    = ir_wr_c   & ~rst;
    assign pc_wr    = pc_wr_c   & ~rst;
    assign regWrite = reg_wr_c  & ~rst;
    assign MemWrite = mem_wr_c  & ~rst;
    assign mem_req  = mem_req_c & ~rst;

    assign ALUSrc      = alu_src_q;
    assign ALUOp       = alu_op_q;
    assign Tipo_Branch = tipo_q;
    assign estado      = state_q;
    assign erro        = (state_q == ERRO);
    assign instr_ret   = cnt_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized self-checking bench for controle_multiciclo against a
// per-instruction reference model of the expected cycle sequence.
module tb_controle_multiciclo;

    localparam int TMO  = 15;
    localparam int CW   = 4;
    localparam int MODC = 16;

    localparam int K_BAD = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] f3 = '0;
    logic [6:0] f7 = '0;
    logic       mem_pronto = 1'b0;
    logic       ir_wr, pc_wr, regWrite, MemWrite, mem_req;
    logic       ALUSrc, MemToReg, SeltipoSouB, selSLT, PCSrc;
    logic [3:0] ALUOp;
    logic [2:0] Tipo_Branch;
    logic [2:0] estado;
    logic       erro;
    logic [CW-1:0] instr_ret;

    int total = 0;
    int bad   = 0;
    int cnt_exp = 0;

    typedef struct {
        logic [2:0] st;
        bit ir, pc, rw, mw, mr, src, pr, m2r, slt, sb;
    } cyc_t;

    cyc_t seq[$];

    controle_multiciclo #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .f3          (f3),
        .f7          (f7),
        .mem_pronto  (mem_pronto),
        .ir_wr       (ir_wr),
        .pc_wr       (pc_wr),
        .regWrite    (regWrite),
        .MemWrite    (MemWrite),
        .mem_req     (mem_req),
        .ALUSrc      (ALUSrc),
        .MemToReg    (MemToReg),
        .SeltipoSouB (SeltipoSouB),
        .selSLT      (selSLT),
        .PCSrc       (PCSrc),
        .ALUOp       (ALUOp),
        .Tipo_Branch (Tipo_Branch),
        .estado      (estado),
        .erro        (erro),
        .instr_ret   (instr_ret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ULA code per f3 for the base flavour; the alternate f7 adds one (ADD->SUB, SRL->SRA).
    function automatic void ref_decode(input logic [6:0] op, input logic [2:0] fn3,
                                       input logic [6:0] fn7, output int cls,
                                       output logic [3:0] aop, output bit src, output bit slt);
        int tab[8] = '{0, 5, 8, 0, 4, 6, 3, 2};
        bit alt = (fn7 == 7'h20);
        bit zero = (fn7 == 7'h00);
        cls = K_BAD; aop = 4'd0; src = 0; slt = 0;
        if (op == 7'h33 || op == 7'h13) begin
            bit is_r = (op == 7'h33);
            bit ok;
            if (fn3 == 3'd3)           ok = 0;
            else if (fn3 == 3'd1)      ok = zero;
            else if (fn3 == 3'd5)      ok = zero || alt;
            else if (fn3 == 3'd0)      ok = !is_r || zero || alt;
            else                       ok = !is_r || zero;
            if (ok) begin
                cls = is_r ? K_R : K_I;
                aop = 4'(tab[fn3] + ((alt && (fn3 == 3'd5 || (fn3 == 3'd0 && is_r))) ? 1 : 0));
                src = !is_r;
                slt = (fn3 == 3'd2);
            end
        end else if (op == 7'h03) begin
            cls = K_LD; src = 1;
        end else if (op == 7'h23) begin
            cls = K_ST; src = 1;
        end else if (op == 7'h63 && fn3 != 3'd2 && fn3 != 3'd3) begin
            cls = K_BR; aop = 4'd1;
        end
    endfunction

    function automatic cyc_t mk(input logic [2:0] st);
        cyc_t c;
        c = '{st: st, default: 0};
        return c;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        mem_pronto = 1'b0;
        #1;
        check("rst_ir_wr", ir_wr, 0);
        check("rst_pc_wr", pc_wr, 0);
        check("rst_mem_req", mem_req, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt_exp = 0;
    endtask

    // Entered and left at a falling edge with the DUT in BUSCA (unless it faults).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] fn3,
                             input logic [6:0] fn7, input int waits);
        int cls; logic [3:0] aop; bit src, slt, timeout, is_st;
        cyc_t c;
        ref_decode(op, fn3, fn7, cls, aop, src, slt);
        timeout = (waits >= TMO);
        is_st = (cls == K_ST);
        seq.delete();
        c = mk(0); c.ir = 1; seq.push_back(c);
        seq.push_back(mk(1));
        if (cls == K_BAD) begin
            seq.push_back(mk(7)); seq.push_back(mk(7));
        end else if (cls == K_R || cls == K_I) begin
            seq.push_back(mk(2));
            c = mk(4); c.rw = 1; c.pc = 1; c.slt = slt; seq.push_back(c);
        end else if (cls == K_BR) begin
            c = mk(2); c.pc = 1; c.src = 1; seq.push_back(c);
        end else begin
            seq.push_back(mk(2));
            for (int i = 0; i < (timeout ? TMO : waits); i++) begin
                c = mk(3); c.mr = 1; c.mw = is_st; c.sb = is_st; seq.push_back(c);
            end
            if (timeout) begin
                seq.push_back(mk(7)); seq.push_back(mk(7));
            end else begin
                c = mk(3); c.mr = 1; c.mw = is_st; c.sb = is_st; c.pr = 1; c.pc = is_st;
                seq.push_back(c);
                if (!is_st) begin
                    c = mk(4); c.rw = 1; c.pc = 1; c.m2r = 1; seq.push_back(c);
                end
            end
        end

        opcode = op; f3 = fn3; f7 = fn7;
        foreach (seq[k]) begin
            mem_pronto = seq[k].pr;
            #1;
            check("estado", estado, seq[k].st);
            check("erro", erro, seq[k].st == 3'd7);
            check("ir_wr", ir_wr, seq[k].ir);
            check("pc_wr", pc_wr, seq[k].pc);
            check("regWrite", regWrite, seq[k].rw);
            check("MemWrite", MemWrite, seq[k].mw);
            check("mem_req", mem_req, seq[k].mr);
            check("PCSrc", PCSrc, seq[k].src);
            check("MemToReg", MemToReg, seq[k].m2r);
            check("selSLT", selSLT, seq[k].slt);
            check("SeltipoSouB", SeltipoSouB, seq[k].sb);
            check("instr_ret", instr_ret, cnt_exp);
            if (seq[k].st == 3'd2) begin
                check("ALUOp", ALUOp, aop);
                check("ALUSrc", ALUSrc, src);
                if (cls == K_BR) check("Tipo_Branch", Tipo_Branch, fn3);
            end
            if (seq[k].pc) cnt_exp = (cnt_exp + 1) % MODC;
            @(negedge clk);
        end
        mem_pronto = 1'b0;
        if (cls == K_BAD || (timeout && (cls == K_LD || cls == K_ST))) do_reset();
    endtask

    initial begin
        logic [31:0] add_word;
        do_reset();
        do_reset();
        check("rst_estado", estado, 0);
        check("rst_erro", erro, 0);
        check("rst_instr_ret", instr_ret, 0);
        check("rst_ALUOp", ALUOp, 0);

        add_word = 32'h002081B3;
        run_instr(add_word[6:0], add_word[14:12], add_word[31:25], 0);
        check("add_retired", instr_ret, 1);
        run_instr(7'h03, 3'd2, 7'h00, 2);
        run_instr(7'h23, 3'd2, 7'h00, 99);
        run_instr(7'h63, 3'd0, 7'h00, 0);
        run_instr(7'h7F, 3'd0, 7'h00, 0);
        run_instr(7'h23, 3'd2, 7'h00, TMO - 1);
        run_instr(7'h33, 3'd2, 7'h00, 0);
        run_instr(7'h13, 3'd5, 7'h20, 0);

        // Reset while a store waits in MEM.
        opcode = 7'h23; f3 = 3'd2; f7 = 7'h00; mem_pronto = 1'b0;
        repeat (4) @(negedge clk);
        check("midmem_estado", estado, 3);
        check("midmem_MemWrite_pre", MemWrite, 1);
        rst = 1'b1;
        #1;
        check("midmem_MemWrite", MemWrite, 0);
        check("midmem_mem_req", mem_req, 0);
        check("midmem_pc_wr", pc_wr, 0);
        @(negedge clk);
        check("midmem_next_estado", estado, 0);
        check("midmem_instr_ret", instr_ret, 0);
        rst = 1'b0;
        cnt_exp = 0;

        for (int n = 0; n < 16; n++) begin
            run_instr(7'h33, 3'd0, 7'h00, 0);
            if (n == 14) check("wrap_15", instr_ret, 15);
        end
        check("wrap_0", instr_ret, 0);

        for (int n = 0; n < 300; n++) begin
            logic [6:0] op, fn7;
            logic [2:0] fn3;
            int w, r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 9: op = 7'h33;
                2, 3:    op = 7'h13;
                4:       op = 7'h03;
                5:       op = 7'h23;
                6, 7:    op = 7'h63;
                default: op = 7'($urandom);
            endcase
            fn3 = 3'($urandom);
            r = $urandom_range(0, 5);
            fn7 = (r < 3) ? 7'h00 : (r < 5) ? 7'h20 : 7'($urandom);
            r = $urandom_range(0, 19);
            w = (r == 19) ? TMO + 5 : (r == 18) ? TMO - 1 : int'($urandom_range(0, 4));
            run_instr(op, fn3, fn7, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
